// File: rtl/sprite_line_buffer_dbl.sv
// Double-buffered sprite line buffer: the renderer owns one line while the composer reads and
// erases the other. Each line is split over interleaved banks so an erase clears BANKS pixels per cycle.
module sprite_line_buffer_dbl #(
  parameter int                DATA_W     = 16,
  parameter int                LINE_W     = 640,
  parameter int                IDX_W      = 10,
  parameter int                BANKS      = 4,
  parameter logic [DATA_W-1:0] ERASE_VAL  = '0,
  parameter bit                TRANSP_EN  = 1'b1,
  parameter logic [DATA_W-1:0] TRANSP_KEY = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              swap_req,
  input  logic [IDX_W-1:0]  renderer_rd_idx,
  output logic [DATA_W-1:0] renderer_rd_data,
  input  logic [IDX_W-1:0]  renderer_wr_idx,
  input  logic [DATA_W-1:0] renderer_wr_data,
  input  logic              renderer_wr_en,
  input  logic [IDX_W-1:0]  composer_rd_idx,
  output logic [DATA_W-1:0] composer_rd_data,
  input  logic              composer_erase_start,
  output logic              erase_busy,
  output logic              swap_pending,
  output logic              active_render_buffer
);
  localparam int BSEL_W = $clog2(BANKS);
  localparam int WORD_W = IDX_W - BSEL_W;
  localparam int DEPTH  = LINE_W / BANKS;
  localparam logic [IDX_W:0]    LINE_LIM  = (IDX_W + 1)'(LINE_W);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(DEPTH - 1);

  typedef enum logic {IDLE, BUSY} erase_state_t;

  erase_state_t      state_reg, state_next;
  logic [WORD_W-1:0] cnt_reg, cnt_next;
  logic              target_reg, target_next;
  logic              pending_reg, pending_next;
  logic              active_reg, active_next;
  logic              erase_done;
  logic              erase_we;

  logic [BSEL_W-1:0] wr_bank, r_bank, c_bank;
  logic [WORD_W-1:0] wr_word, r_word, c_word;
  logic              wr_ok, r_oor, c_oor;

  assign wr_bank = renderer_wr_idx[BSEL_W-1:0];
  assign wr_word = renderer_wr_idx[IDX_W-1:BSEL_W];
  assign wr_ok   = renderer_wr_en && ({1'b0, renderer_wr_idx} < LINE_LIM) &&
                   !(TRANSP_EN && (renderer_wr_data == TRANSP_KEY));

  // Out-of-range reads are steered to word 0 so the array is never indexed past its depth.
  assign r_oor  = !({1'b0, renderer_rd_idx} < LINE_LIM);
  assign r_bank = renderer_rd_idx[BSEL_W-1:0];
  assign r_word = r_oor ? '0 : renderer_rd_idx[IDX_W-1:BSEL_W];
  assign c_oor  = !({1'b0, composer_rd_idx} < LINE_LIM);
  assign c_bank = composer_rd_idx[BSEL_W-1:0];
  assign c_word = c_oor ? '0 : composer_rd_idx[IDX_W-1:BSEL_W];

  assign erase_busy           = (state_reg == BUSY);
  assign erase_we             = erase_busy && rst_n;
  assign swap_pending         = pending_reg;
  assign active_render_buffer = active_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    target_next  = target_reg;
    pending_next = pending_reg;
    active_next  = active_reg;
    erase_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (composer_erase_start) begin
          state_next  = BUSY;
          cnt_next    = '0;
          target_next = ~active_reg;
        end
      end
      BUSY: begin
        if (composer_erase_start) begin
          cnt_next    = '0;
          target_next = ~active_reg;
        end else if (cnt_reg == LAST_WORD) begin
          state_next = IDLE;
          cnt_next   = '0;
          erase_done = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // A request arriving on the final erase cycle merges with the deferred one: single toggle.
    if (erase_done) begin
      if (pending_reg || swap_req) active_next = ~active_reg;
      pending_next = 1'b0;
    end else if (swap_req) begin
      if (erase_busy || composer_erase_start) pending_next = 1'b1;
      else                                    active_next  = ~active_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      target_reg  <= 1'b0;
      pending_reg <= 1'b0;
      active_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      target_reg  <= target_next;
      pending_reg <= pending_next;
      active_reg  <= active_next;
    end
  end

  // Bank array entry gi = {buffer, bank}; each bank is one simple dual-port RAM.
  logic [DATA_W-1:0] bank_q [2*BANKS];

  for (genvar gi = 0; gi < 2 * BANKS; gi++) begin : g_bank
    localparam logic              BUF_ID  = 1'(gi / BANKS);
    localparam logic [BSEL_W-1:0] BANK_ID = BSEL_W'(gi % BANKS);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] q_reg;
    logic              we;
    logic [WORD_W-1:0] waddr, raddr;
    logic [DATA_W-1:0] wdata;

    always_comb begin
      we    = 1'b0;
      waddr = wr_word;
      wdata = renderer_wr_data;
      if (erase_we && (target_reg == BUF_ID)) begin
        we    = 1'b1;
        waddr = cnt_reg;
        wdata = ERASE_VAL;
      end else if (wr_ok && (active_reg == BUF_ID) && (wr_bank == BANK_ID)) begin
        we = 1'b1;
      end
    end

    assign raddr = (active_reg == BUF_ID) ? r_word : c_word;

    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      q_reg <= mem[raddr];
    end

    assign bank_q[gi] = q_reg;
  end

  logic              rd_valid_reg;
  logic              r_oor_reg, c_oor_reg, r_buf_reg, c_buf_reg;
  logic [BSEL_W-1:0] r_bank_reg, c_bank_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) rd_valid_reg <= 1'b0;
    else        rd_valid_reg <= 1'b1;
  end

  // Buffer and bank selects travel with the read so a swap one cycle later cannot redirect it.
  always_ff @(posedge clk) begin
    r_oor_reg  <= r_oor;
    c_oor_reg  <= c_oor;
    r_bank_reg <= r_bank;
    c_bank_reg <= c_bank;
    r_buf_reg  <= active_reg;
    c_buf_reg  <= ~active_reg;
  end

  assign renderer_rd_data = !rd_valid_reg ? '0 :
                            r_oor_reg     ? ERASE_VAL : bank_q[{r_buf_reg, r_bank_reg}];
  assign composer_rd_data = !rd_valid_reg ? '0 :
                            c_oor_reg     ? ERASE_VAL : bank_q[{c_buf_reg, c_bank_reg}];
endmodule

// File: tb/tb_sprite_line_buffer_dbl.sv
// Self-checking bench: directed scenarios plus random traffic, compared every cycle against a
// pixel-array model of both lines, the erase progress and the swap ownership.
module tb_sprite_line_buffer_dbl;
  localparam int DATA_W = 16;
  localparam int LINE_W = 640;
  localparam int IDX_W  = 10;
  localparam int BANKS  = 4;
  localparam int WORDS  = LINE_W / BANKS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              swap_req = 1'b0;
  logic [IDX_W-1:0]  renderer_rd_idx = '0;
  logic [DATA_W-1:0] renderer_rd_data;
  logic [IDX_W-1:0]  renderer_wr_idx = '0;
  logic [DATA_W-1:0] renderer_wr_data = '0;
  logic              renderer_wr_en = 1'b0;
  logic [IDX_W-1:0]  composer_rd_idx = '0;
  logic [DATA_W-1:0] composer_rd_data;
  logic              composer_erase_start = 1'b0;
  logic              erase_busy;
  logic              swap_pending;
  logic              active_render_buffer;

  sprite_line_buffer_dbl dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .swap_req             (swap_req),
    .renderer_rd_idx      (renderer_rd_idx),
    .renderer_rd_data     (renderer_rd_data),
    .renderer_wr_idx      (renderer_wr_idx),
    .renderer_wr_data     (renderer_wr_data),
    .renderer_wr_en       (renderer_wr_en),
    .composer_rd_idx      (composer_rd_idx),
    .composer_rd_data     (composer_rd_data),
    .composer_erase_start (composer_erase_start),
    .erase_busy           (erase_busy),
    .swap_pending         (swap_pending),
    .active_render_buffer (active_render_buffer)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: pixel values per buffer (-1 = never written), owner bit, erase cycles left, pending flag.
  int mdl_mem [2][LINE_W];
  bit m_active = 1'b0;
  bit m_pending = 1'b0;
  bit m_ebuf = 1'b0;
  int m_left = 0;
  int exp_r = -1;
  int exp_c = -1;
  bit m_started = 1'b0;

  always @(posedge clk) begin
    int ri, ci, wi, base;
    bit busy, done;
    ri = int'(renderer_rd_idx);
    ci = int'(composer_rd_idx);
    if (!rst_n) begin
      exp_r = 0;
      exp_c = 0;
      m_left = 0;
      m_pending = 1'b0;
      m_active = 1'b0;
    end else begin
      exp_r = (ri >= LINE_W) ? 0 : mdl_mem[m_active][ri];
      exp_c = (ci >= LINE_W) ? 0 : mdl_mem[!m_active][ci];
      busy = (m_left > 0);
      wi = int'(renderer_wr_idx);
      if (renderer_wr_en && wi < LINE_W && renderer_wr_data != 16'h0000)
        mdl_mem[m_active][wi] = int'(renderer_wr_data);
      if (busy) begin
        base = (WORDS - m_left) * BANKS;
        for (int b = 0; b < BANKS; b++) mdl_mem[m_ebuf][base + b] = 0;
      end
      done = busy && (m_left == 1) && !composer_erase_start;
      if (composer_erase_start) begin
        m_left = WORDS;
        m_ebuf = !m_active;
      end else if (busy) begin
        m_left = m_left - 1;
      end
      if (done) begin
        if (m_pending || swap_req) m_active = !m_active;
        m_pending = 1'b0;
      end else if (swap_req) begin
        if (busy || composer_erase_start) m_pending = 1'b1;
        else                              m_active = !m_active;
      end
    end
    m_started = 1'b1;
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("erase_busy", 32'(erase_busy), 32'(m_left > 0));
      chk("swap_pending", 32'(swap_pending), 32'(m_pending));
      chk("active_render_buffer", 32'(active_render_buffer), 32'(m_active));
      if (exp_r >= 0) chk("renderer_rd_data", 32'(renderer_rd_data), 32'(exp_r));
      if (exp_c >= 0) chk("composer_rd_data", 32'(composer_rd_data), 32'(exp_c));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < LINE_W; i++) mdl_mem[b][i] = -1;

    repeat (3) tick();
    chk("reset_busy", 32'(erase_busy), 32'd0);
    chk("reset_pending", 32'(swap_pending), 32'd0);
    chk("reset_active", 32'(active_render_buffer), 32'd0);
    chk("reset_rdata", 32'(composer_rd_data), 32'd0);
    rst_n = 1'b1;
    $display("reset released");

    // Fill render buffer 0 with idx+1
    for (int i = 0; i < LINE_W; i++) begin
      renderer_wr_en = 1'b1;
      renderer_wr_idx = IDX_W'(i);
      renderer_wr_data = DATA_W'(i + 1);
      renderer_rd_idx = IDX_W'($urandom_range(0, 1023));
      tick();
    end
    renderer_wr_en = 1'b0;
    $display("filled buffer 0 with idx+1");

    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("idle_swap_active", 32'(active_render_buffer), 32'd1);
    $display("idle swap -> active=%0d", active_render_buffer);

    // Composer reads buffer 0 while the renderer fills buffer 1
    for (int i = 0; i < LINE_W; i++) begin
      composer_rd_idx = IDX_W'(i);
      renderer_wr_en = 1'b1;
      renderer_wr_idx = IDX_W'(i);
      renderer_wr_data = DATA_W'($urandom_range(1, 65535));
      renderer_rd_idx = IDX_W'($urandom_range(0, 1023));
      tick();
      chk("composer_line_read", 32'(composer_rd_data), 32'(i + 1));
    end
    renderer_wr_en = 1'b0;
    $display("composer read back 640 pixels of buffer 0");

    renderer_wr_en = 1'b1;
    renderer_wr_idx = 10'd5;   renderer_wr_data = 16'h1234; tick();
    renderer_wr_idx = 10'd5;   renderer_wr_data = 16'h0000; tick();
    renderer_wr_idx = 10'd700; renderer_wr_data = 16'hBEEF; tick();
    renderer_wr_idx = 10'd320; renderer_wr_data = 16'hABCD; tick();
    renderer_wr_en = 1'b0;
    renderer_rd_idx = 10'd5;   tick();
    chk("transparent_write_dropped", 32'(renderer_rd_data), 32'h1234);
    renderer_rd_idx = 10'd700; tick();
    chk("out_of_range_read", 32'(renderer_rd_data), 32'h0);
    $display("transparent and out-of-range writes");

    // Erase composer buffer 0 while the renderer keeps drawing pixels 0..299
    composer_erase_start = 1'b1;
    tick();
    composer_erase_start = 1'b0;
    cyc = 0;
    while (erase_busy && cyc < 400) begin
      cyc++;
      renderer_wr_en = 1'b1;
      renderer_wr_idx = IDX_W'($urandom_range(0, 299));
      if (renderer_wr_idx == 10'd5) renderer_wr_idx = 10'd6;
      renderer_wr_data = DATA_W'($urandom_range(1, 65535));
      composer_rd_idx = IDX_W'($urandom_range(0, 1023));
      renderer_rd_idx = IDX_W'($urandom_range(0, 1023));
      tick();
    end
    renderer_wr_en = 1'b0;
    chk("erase_busy_cycles", 32'(cyc), 32'd160);
    for (int i = 0; i < LINE_W; i++) begin
      composer_rd_idx = IDX_W'(i);
      tick();
      chk("erased_pixel", 32'(composer_rd_data), 32'h0);
    end
    renderer_rd_idx = 10'd5;   tick();
    chk("render_untouched_5", 32'(renderer_rd_data), 32'h1234);
    renderer_rd_idx = 10'd320; tick();
    chk("render_untouched_320", 32'(renderer_rd_data), 32'hABCD);
    $display("erase took %0d cycles", cyc);

    // Three swap requests during an erase produce exactly one deferred toggle
    composer_erase_start = 1'b1;
    tick();
    composer_erase_start = 1'b0;
    cyc = 0;
    while (erase_busy && cyc < 400) begin
      if (cyc == 11) begin
        chk("deferred_pending", 32'(swap_pending), 32'd1);
        chk("deferred_no_toggle_yet", 32'(active_render_buffer), 32'd1);
      end
      swap_req = (cyc == 10 || cyc == 30 || cyc == 50);
      cyc++;
      tick();
    end
    swap_req = 1'b0;
    chk("deferred_erase_cycles", 32'(cyc), 32'd160);
    chk("deferred_toggle_once", 32'(active_render_buffer), 32'd0);
    chk("deferred_pending_clear", 32'(swap_pending), 32'd0);
    $display("deferred swap -> active=%0d", active_render_buffer);

    // Reset with cnt=80 aborts the erase of buffer 1 and drops the pending swap
    composer_erase_start = 1'b1;
    tick();
    composer_erase_start = 1'b0;
    for (int k = 0; k < 80; k++) begin
      swap_req = (k == 20);
      tick();
    end
    swap_req = 1'b0;
    chk("abort_pending_before", 32'(swap_pending), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("abort_busy", 32'(erase_busy), 32'd0);
    chk("abort_pending", 32'(swap_pending), 32'd0);
    chk("abort_active", 32'(active_render_buffer), 32'd0);
    rst_n = 1'b1;
    composer_rd_idx = 10'd319; tick();
    chk("abort_word79_erased", 32'(composer_rd_data), 32'h0);
    composer_rd_idx = 10'd320; tick();
    chk("abort_word80_intact", 32'(composer_rd_data), 32'hABCD);
    $display("reset mid-erase");

    // Read sampled on the same edge as the swap returns pre-swap data
    composer_rd_idx = 10'd320;
    renderer_rd_idx = 10'd320;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("swap_read_composer_old", 32'(composer_rd_data), 32'hABCD);
    chk("swap_read_renderer_old", 32'(renderer_rd_data), 32'h0);
    chk("swap_read_active", 32'(active_render_buffer), 32'd1);
    tick();
    chk("swap_read_composer_new", 32'(composer_rd_data), 32'h0);
    chk("swap_read_renderer_new", 32'(renderer_rd_data), 32'hABCD);
    $display("read across swap");

    // Random traffic, checked cycle by cycle against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        renderer_wr_en = 1'b0;
        swap_req = 1'b0;
        composer_erase_start = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        swap_req = ($urandom_range(0, 31) == 0);
        composer_erase_start = ($urandom_range(0, 99) == 0);
        renderer_wr_en = ($urandom_range(0, 3) != 0);
        renderer_wr_idx = IDX_W'($urandom_range(0, 700));
        renderer_wr_data = ($urandom_range(0, 3) == 0) ? 16'h0000 : DATA_W'($urandom_range(1, 65535));
        renderer_rd_idx = IDX_W'($urandom_range(0, 700));
        composer_rd_idx = IDX_W'($urandom_range(0, 700));
        tick();
      end
    end
    swap_req = 1'b0;
    composer_erase_start = 1'b0;
    renderer_wr_en = 1'b0;
    tick();
    $display("random traffic done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
